vending_fsm_param: RTL and testbench

Parametrised successor to the fixed-price vending controller. It accumulates coin credit from a 2-bit coin code with configurable coin values and price. It dispenses via a one-cycle pr_en pulse and returns change, cancel refunds and rejected coins. It also tracks product stock with sold-out and restock handling. It sits between the coin acceptor front end and the dispense/change actuators.

---
 rtl/vending_fsm_param.sv | 126 ++++++++++++
 tb/tb_vending_fsm_param.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/vending_fsm_param.sv
// Parametrised vending controller.
// It accumulates coin credit and vends once the price is reached. It also
// returns change and cancel refunds, rejects coins while vending or sold out,
// and tracks product stock with restock. Every output is registered.
module vending_fsm_param #(
  parameter int unsigned PRICE    = 15,
  parameter int unsigned VAL1     = 5,
  parameter int unsigned VAL2     = 10,
  parameter int unsigned VAL3     = 25,
  parameter int unsigned STOCK    = 3,
  parameter int unsigned CREDIT_W = 6,
  localparam int unsigned STOCK_W = $clog2(STOCK + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                cancel,
  input  logic                restock,
  output logic                pr_en,
  output logic [CREDIT_W-1:0] change,
  output logic                chg_valid,
  output logic                coin_rej,
  output logic [CREDIT_W-1:0] credit,
  output logic                sold_out,
  output logic [STOCK_W-1:0]  stock_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCUM    = 2'd1,
    VEND     = 2'd2,
    SOLD_OUT = 2'd3
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [STOCK_W-1:0]  STOCK_C = STOCK_W'(STOCK);

  state_t              state;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] sum;
  logic [CREDIT_W-1:0] excess;

  // Decode the sampled coin and form the candidate credit and vend excess.
  // NOTE: every combinational output is assigned on every path (case default
  // included), so no latch is inferred.
  always_comb begin
    coin_val = '0;
    case (coin)
      2'b01:   coin_val = CREDIT_W'(VAL1);
      2'b10:   coin_val = CREDIT_W'(VAL2);
      2'b11:   coin_val = CREDIT_W'(VAL3);
      default: coin_val = '0;
    endcase
    sum    = credit + coin_val;
    excess = sum - PRICE_C;
  end

  // Transaction FSM with registered pulse, credit and stock outputs.
  // NOTE: state is updated with non-blocking assignments only, so every
  // decision in this block sees the values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      credit    <= '0;
      stock_cnt <= STOCK_C;
      pr_en     <= 1'b0;
      chg_valid <= 1'b0;
      change    <= '0;
      coin_rej  <= 1'b0;
      sold_out  <= 1'b0;
    end else begin
      // Pulses default low, so each one lasts exactly one cycle.
      pr_en     <= 1'b0;
      chg_valid <= 1'b0;
      change    <= '0;
      coin_rej  <= 1'b0;

      case (state)
        IDLE, ACCUM: begin
          if (cancel) begin
            // The refund includes any coin sampled on this edge.
            change    <= sum;
            chg_valid <= (sum != '0);
            credit    <= '0;
            state     <= IDLE;
          end else if (sum >= PRICE_C) begin
            pr_en     <= 1'b1;
            change    <= excess;
            chg_valid <= (excess != '0);
            credit    <= '0;
            stock_cnt <= stock_cnt - STOCK_W'(1);
            state     <= VEND;
          end else begin
            credit <= sum;
            state  <= (sum != '0) ? ACCUM : IDLE;
          end
        end

        VEND: begin
          // Coins arriving while vending go back uncredited; cancel is ignored.
          coin_rej <= (coin != 2'b00);
          if (stock_cnt == '0 && !restock) begin
            state    <= SOLD_OUT;
            sold_out <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        SOLD_OUT: begin
          coin_rej <= (coin != 2'b00);
          if (restock) begin
            state    <= IDLE;
            sold_out <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase

      // A restock overrides any decrement made on the same edge.
      if (restock) stock_cnt <= STOCK_C;
    end
  end

endmodule

// File: tb/tb_vending_fsm_param.sv
// Directed bench for vending_fsm_param with default parameters
// (PRICE=15, VAL1/2/3=5/10/25, STOCK=3, CREDIT_W=6).
module tb_vending_fsm_param;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin;
  logic       cancel;
  logic       restock;
  logic       pr_en;
  logic [5:0] change;
  logic       chg_valid;
  logic       coin_rej;
  logic [5:0] credit;
  logic       sold_out;
  logic [1:0] stock_cnt;

  int passed = 0;
  int total  = 0;

  vending_fsm_param dut (
    .clk       (clk),
    .rst       (rst),
    .coin      (coin),
    .cancel    (cancel),
    .restock   (restock),
    .pr_en     (pr_en),
    .change    (change),
    .chg_valid (chg_valid),
    .coin_rej  (coin_rej),
    .credit    (credit),
    .sold_out  (sold_out),
    .stock_cnt (stock_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Present inputs for one edge, then sample 1 ns after that edge.
  task automatic step(input logic [1:0] c, input logic can, input logic rs);
    coin    = c;
    cancel  = can;
    restock = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic check_pulses(input string tag, input logic pe, input logic cv,
                              input logic [5:0] ch, input logic cr);
    check({tag, ".pr_en"},     pr_en,     pe);
    check({tag, ".chg_valid"}, chg_valid, cv);
    check({tag, ".change"},    change,    ch);
    check({tag, ".coin_rej"},  coin_rej,  cr);
  endtask

  initial begin
    rst = 1'b1; coin = 2'b00; cancel = 1'b0; restock = 1'b0;
    #12;
    check("rst.credit", credit, 0);
    check("rst.stock", stock_cnt, 3);
    check("rst.sold_out", sold_out, 0);
    check_pulses("rst", 0, 0, 0, 0);
    rst = 1'b0;

    // Three 5-unit coins: exact price, no change.
    step(2'b01, 0, 0); check("acc5.credit", credit, 5);  check("acc5.pr_en", pr_en, 0);
    step(2'b01, 0, 0); check("acc10.credit", credit, 10);
    step(2'b01, 0, 0);
    check_pulses("vend1", 1, 0, 0, 0);
    check("vend1.stock", stock_cnt, 2);
    check("vend1.credit", credit, 0);
    step(2'b00, 0, 0); check_pulses("vend1_exit", 0, 0, 0, 0);

    // 10 + 10: vend with change 5.
    step(2'b10, 0, 0); check("acc10b.credit", credit, 10);
    step(2'b10, 0, 0);
    check_pulses("vend2", 1, 1, 5, 0);
    check("vend2.stock", stock_cnt, 1);
    step(2'b00, 0, 0); check_pulses("vend2_exit", 0, 0, 0, 0);

    // Cancel with a coin on the same edge: refund 15, no vend despite sum>=PRICE.
    step(2'b01, 0, 0); check("acc5c.credit", credit, 5);
    step(2'b10, 1, 0);
    check_pulses("cancel", 0, 1, 15, 0);
    check("cancel.credit", credit, 0);
    check("cancel.stock", stock_cnt, 1);
    step(2'b00, 1, 0); check_pulses("cancel0", 0, 0, 0, 0);

    // Single 25 coin: vend with change 10, last unit.
    step(2'b11, 0, 0);
    check_pulses("vend3", 1, 1, 10, 0);
    check("vend3.stock", stock_cnt, 0);
    // Coin during VEND is rejected; stock empty, so enter SOLD_OUT.
    step(2'b01, 0, 0);
    check_pulses("vendrej", 0, 0, 0, 1);
    check("vendrej.credit", credit, 0);
    check("vendrej.sold_out", sold_out, 1);
    step(2'b10, 0, 0);
    check("so_coin.coin_rej", coin_rej, 1);
    check("so_coin.credit", credit, 0);
    check("so_coin.sold_out", sold_out, 1);
    step(2'b00, 1, 0); check_pulses("so_cancel", 0, 0, 0, 0);
    check("so_cancel.sold_out", sold_out, 1);
    step(2'b00, 0, 1);
    check("restock.sold_out", sold_out, 0);
    check("restock.stock", stock_cnt, 3);
    check("restock.coin_rej", coin_rej, 0);
    step(2'b10, 0, 0); check("resume.credit", credit, 10);
    step(2'b01, 0, 0);
    check_pulses("resume_vend", 1, 0, 0, 0);
    check("resume_vend.stock", stock_cnt, 2);
    step(2'b00, 0, 0);

    // Restock on the vend edge wins over the decrement.
    step(2'b11, 0, 1);
    check("rs_vend.pr_en", pr_en, 1);
    check("rs_vend.stock", stock_cnt, 3);
    step(2'b00, 0, 0); check("rs_vend_exit.sold_out", sold_out, 0);

    // Asynchronous reset between edges discards credit 10 without refund.
    step(2'b10, 0, 0); check("pre_rst.credit", credit, 10);
    coin = 2'b00;
    #2 rst = 1'b1;
    #1;
    check("arst.credit", credit, 0);
    check("arst.stock", stock_cnt, 3);
    check_pulses("arst", 0, 0, 0, 0);
    #1 rst = 1'b0;
    step(2'b00, 0, 0);
    check_pulses("post_rst", 0, 0, 0, 0);
    step(2'b01, 0, 0); check("post_rst.credit", credit, 5);

    // Async reset while a vend pulse is high clears it immediately.
    step(2'b10, 0, 0);
    check("pre_rst2.pr_en", pr_en, 1);
    #2 rst = 1'b1;
    #1;
    check_pulses("arst2", 0, 0, 0, 0);
    check("arst2.stock", stock_cnt, 3);
    #1 rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
